// File: rtl/fmap_stream_pkg.sv
// Shared types and dimension helpers for the feature-map streamer.
// Used by fmap_streamer; the pooled build is selected with FMAP_STREAM_POOL_EN.
package fmap_stream_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } fmap_state_t;

  // Dimension of a valid convolution of a size x size input with a ker x ker kernel.
  function automatic int out_dim(input int size, input int ker);
    return size - ker + 1;
  endfunction

  // Dimension after 2x2 stride-2 pooling; an odd trailing row/column is discarded.
  function automatic int pool_dim(input int n);
    return n / 2;
  endfunction

endpackage

// File: rtl/fmap_streamer_maxpool2x2_reduce.sv
// Combinational signed maximum of a 2x2 pooling window.
// Only instantiated by fmap_streamer when FMAP_STREAM_POOL_EN is defined.
module maxpool2x2_reduce #(
  parameter int WIDTH_BIT = 8
) (
  input  logic signed [WIDTH_BIT-1:0] in_a,
  input  logic signed [WIDTH_BIT-1:0] in_b,
  input  logic signed [WIDTH_BIT-1:0] in_c,
  input  logic signed [WIDTH_BIT-1:0] in_d,
  output logic signed [WIDTH_BIT-1:0] max_out
);

  logic signed [WIDTH_BIT-1:0] max_ab;
  logic signed [WIDTH_BIT-1:0] max_cd;

  // Two-level compare tree; all operands signed so the compare is signed.
  always_comb begin
    max_ab  = (in_a > in_b) ? in_a : in_b;
    max_cd  = (in_c > in_d) ? in_c : in_d;
    max_out = (max_ab > max_cd) ? max_ab : max_cd;
  end

endmodule

// File: rtl/fmap_streamer.sv
// fmap_streamer: captures the whole convolution output map on the rising edge
// of done_in and replays it row-major over a valid/ready stream.
// Optional feature: define FMAP_STREAM_POOL_EN for 2x2 stride-2 max-pooling
// while streaming (emitted dimension becomes floor(OUT/2)).
module fmap_streamer
  import fmap_stream_pkg::*;
#(
  parameter int SIZE      = 7,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        done_in,
  input  logic [out_dim(SIZE, SIZEKer)-1:0][out_dim(SIZE, SIZEKer)-1:0][WIDTH_BIT-1:0] fmap_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH_BIT-1:0] out_data,
  output logic [WIDTH_BIT-1:0]        out_row,
  output logic [WIDTH_BIT-1:0]        out_col,
  output logic                        out_last_col,
  output logic                        out_last,
  output logic                        busy,
  output logic                        overrun
);

  localparam int OUT = out_dim(SIZE, SIZEKer);
`ifdef FMAP_STREAM_POOL_EN
  localparam int ODIM = pool_dim(OUT);
`else
  localparam int ODIM = OUT;
`endif
  // Index width covers the captured map, which is never smaller than the emitted one.
  localparam int IDXW = (OUT > 1) ? $clog2(OUT) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ODIM - 1);

  fmap_state_t state_q, state_d;
  logic [IDXW-1:0] row_q, row_d;
  logic [IDXW-1:0] col_q, col_d;
  logic            done_q, done_d;
  logic            arm_q, arm_d;
  logic            overrun_q, overrun_d;
  logic [OUT-1:0][OUT-1:0][WIDTH_BIT-1:0] fbuf_q, fbuf_d;

  logic                        start;
  logic                        handshake;
  logic                        capture;
  logic                        at_last_col;
  logic                        at_last;
  logic signed [WIDTH_BIT-1:0] elem;

  // A frame starts only on a fresh rise. arm_q blocks a level that was already
  // high during reset from being seen as a rise once reset releases.
  assign start       = done_in & ~done_q & arm_q;
  assign handshake   = (state_q == STREAM) & out_ready;
  assign at_last_col = (col_q == LAST_IDX);
  assign at_last     = at_last_col & (row_q == LAST_IDX);

`ifdef FMAP_STREAM_POOL_EN
  if (OUT < 2) begin : g_pool_too_small
    $error("fmap_streamer: pooling needs a captured map of at least 2x2");
  end

  logic [IDXW-1:0] r0, r1, c0, c1;
  assign r0 = IDXW'({row_q, 1'b0});
  assign r1 = IDXW'({row_q, 1'b1});
  assign c0 = IDXW'({col_q, 1'b0});
  assign c1 = IDXW'({col_q, 1'b1});

  maxpool2x2_reduce #(
    .WIDTH_BIT (WIDTH_BIT)
  ) u_pool (
    .in_a    (fbuf_q[r0][c0]),
    .in_b    (fbuf_q[r0][c1]),
    .in_c    (fbuf_q[r1][c0]),
    .in_d    (fbuf_q[r1][c1]),
    .max_out (elem)
  );
`else
  assign elem = fbuf_q[row_q][col_q];
`endif

  // State and control registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      done_q    <= 1'b0;
      arm_q     <= ~done_in;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      done_q    <= done_d;
      arm_q     <= arm_d;
      overrun_q <= overrun_d;
    end
  end

  // Frame buffer: plain datapath storage, only its content after a capture matters.
  always_ff @(posedge clock) begin
    fbuf_q <= fbuf_d;
  end

  // Next-state: capture on accepted start, index walk on handshakes, overrun on drops.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
    done_d    = done_in;
    arm_d     = arm_q | ~done_in;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          row_d   = '0;
          col_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (handshake) begin
          if (at_last_col) begin
            col_d = '0;
            row_d = row_q + IDXW'(1);
          end else begin
            col_d = col_q + IDXW'(1);
          end
        end
        if (handshake & at_last) begin
          // A start landing on the final beat chains straight into the next frame.
          if (start) begin
            capture = 1'b1;
            row_d   = '0;
            col_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (start) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    fbuf_d = capture ? fmap_in : fbuf_q;
  end

  // Outputs: zero outside STREAM so reset and idle present a clean stream.
  always_comb begin
    out_valid    = 1'b0;
    busy         = 1'b0;
    out_data     = '0;
    out_row      = '0;
    out_col      = '0;
    out_last_col = 1'b0;
    out_last     = 1'b0;
    overrun      = overrun_q;
    if (state_q == STREAM) begin
      out_valid    = 1'b1;
      busy         = 1'b1;
      out_data     = elem;
      out_row      = WIDTH_BIT'(row_q);
      out_col      = WIDTH_BIT'(col_q);
      out_last_col = at_last_col;
      out_last     = at_last;
    end
  end

endmodule
